// File: rtl/calc_inst_sequencer_pkg.sv
// Shared definitions for the calculator instruction sequencer.
// Instruction word layout: {op[7:6], ra[5:4], rb/immd[3:0]}.
// The sequencer only looks at the opcode field; operands pass through untouched.
package calc_inst_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_ADD  = 2'b01,
    OP_MULT = 2'b10,
    OP_SEND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_SEND = 3'd3,
    ST_GAP       = 3'd4,
    ST_WAIT_STEP = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] ra;
    logic [3:0] rb;
  } inst_t;

endpackage

// File: rtl/calc_inst_sequencer_if.sv
// Control/status bundle between a program loader/host and the sequencer.
// Latency: wires only. Backpressure: none; send_done paces SEND issues.
// Ports: loader (prog_clr/prog_wr/prog_wdata), run control (start/step_mode/step/
//   abort), UART completion (send_done), issue port (inst_vld/inst_wd), status
//   (busy/done/err_tmo/load_ovf/pc/prog_len). master = host side, slave = sequencer.
interface calc_inst_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_clr;
  logic              prog_wr;
  logic [7:0]        prog_wdata;
  logic              start;
  logic              step_mode;
  logic              step;
  logic              abort;
  logic              send_done;
  logic              inst_vld;
  logic [7:0]        inst_wd;
  logic              busy;
  logic              done;
  logic              err_tmo;
  logic              load_ovf;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output prog_clr, prog_wr, prog_wdata, start, step_mode, step, abort, send_done,
    input  inst_vld, inst_wd, busy, done, err_tmo, load_ovf, pc, prog_len
  );

  modport slave (
    input  prog_clr, prog_wr, prog_wdata, start, step_mode, step, abort, send_done,
    output inst_vld, inst_wd, busy, done, err_tmo, load_ovf, pc, prog_len
  );
endinterface

// File: rtl/calc_inst_sequencer_prog_ram.sv
// Program buffer: DEPTH x 8, one write port, one synchronous read port, no reset.
// Latency: read data appears the cycle after rd_en; holds when rd_en is low.
// Backpressure: none. Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr/rd_data.
module calc_inst_sequencer_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    // Gated read so rd_data doubles as the held inst_wd value between strobes.
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/calc_inst_sequencer.sv
// Replays a stored program of calculator instructions into the datapath issue port.
// Latency: start to first inst_vld 2 cycles; non-SEND issue-to-issue INST_GAP+2.
// Backpressure: a SEND stalls until send_done (or SEND_TMO cycles -> err_tmo).
// Ports: clk, rst_n (async active-low), bus (slave modport of calc_inst_sequencer_if).
module calc_inst_sequencer
  import calc_inst_sequencer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int INST_GAP = 4,
  parameter int SEND_TMO = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_inst_sequencer_if.slave bus
);

  localparam int CNT_MAX = (SEND_TMO > INST_GAP) ? SEND_TMO : INST_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(SEND_TMO - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(INST_GAP - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // shared by GAP and WAIT_SEND, never live together
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              rd_seen_q;      // masks the unreset RAM output until first fetch
  logic              ram_wr, ram_rd;
  logic [7:0]        ram_rdata;
  logic              advance;
  logic              last_inst;
  op_e               cur_op;

  calc_inst_sequencer_prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (len_q[ADDR_W-1:0]),
    .wr_data (bus.prog_wdata),
    .rd_en   (ram_rd),
    .rd_addr (pc_q),
    .rd_data (ram_rdata)
  );

  assign cur_op    = op_e'(ram_rdata[7:6]);
  assign last_inst = ({1'b0, pc_q} == (len_q - LEN_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      if (ram_rd) rd_seen_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    ram_wr  = 1'b0;
    ram_rd  = 1'b0;
    advance = 1'b0;

    if (bus.abort && (state_q != ST_IDLE)) begin
      // Abort wins over step, send_done and timeout: pc and flags stay put.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.prog_clr) begin
            len_d = '0;
            ovf_d = 1'b0;
          end else if (bus.prog_wr) begin
            if (len_q == LEN_FULL) begin
              ovf_d = 1'b1;
            end else begin
              ram_wr = 1'b1;
              len_d  = len_q + LEN_ONE;
            end
          end
          if (bus.start) begin
            pc_d    = '0;
            err_d   = 1'b0;
            state_d = (len_q == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          ram_rd  = 1'b1;
          state_d = bus.step_mode ? ST_WAIT_STEP : ST_ISSUE;
        end
        ST_WAIT_STEP: begin
          if (bus.step) state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          // send_done during ISSUE is deliberately not looked at here.
          cnt_d   = '0;
          state_d = (cur_op == OP_SEND) ? ST_WAIT_SEND : ST_GAP;
        end
        ST_WAIT_SEND: begin
          if (bus.send_done) begin
            advance = 1'b1;
          end else if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) advance = 1'b1;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (advance) begin
        if (last_inst) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_FETCH;
        end
      end
    end
  end

  assign bus.inst_vld = (state_q == ST_ISSUE);
  assign bus.inst_wd  = rd_seen_q ? ram_rdata : 8'h00;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.err_tmo  = err_q;
  assign bus.load_ovf = ovf_q;
  assign bus.pc       = pc_q;
  assign bus.prog_len = len_q;

endmodule

// File: tb/tb_calc_inst_sequencer.sv
// Self-checking bench for calc_inst_sequencer: a timeline model built from the
// latency rules predicts inst_vld/inst_wd/done/busy per cycle, a compare process
// checks them every cycle, and directed checks pin flags, counts and spacings.
module tb_calc_inst_sequencer;

  localparam int GAP = 4;
  localparam int TMO = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_inst_sequencer_if #(.ADDR_W(4)) bus();

  calc_inst_sequencer #(
    .DEPTH    (16),
    .ADDR_W   (4),
    .INST_GAP (GAP),
    .SEND_TMO (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Model state: stored program plus overflow flag, and the expected timeline.
  logic [7:0] mdl_prog[$];
  bit         mdl_ovf = 1'b0;
  bit         exp_issue[int];
  logic [7:0] exp_word[int];
  bit         exp_done[int];
  bit         exp_busy[int];
  bit         start_at[int];
  bit         step_at[int];
  bit         abort_at[int];

  int vld_q[$];
  int done_q[$];
  int send_lat = 0;    // 0 = UART never answers
  int send_due = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // UART stand-in: answers a SEND issue send_lat cycles later.
  always @(posedge clk) begin
    #1;
    bus.send_done = (cyc == send_due);
  end

  always @(negedge clk) begin
    if (bus.inst_vld === 1'b1) begin
      vld_q.push_back(cyc);
      if (bus.inst_wd[7:6] == 2'b11 && send_lat > 0) send_due = cyc + send_lat;
    end
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (chk_on) begin
      check("inst_vld", 32'(bus.inst_vld), exp_issue.exists(cyc));
      if (exp_issue.exists(cyc)) check("inst_wd", 32'(bus.inst_wd), 32'(exp_word[cyc]));
      check("done", 32'(bus.done), exp_done.exists(cyc));
      check("busy", 32'(bus.busy), exp_busy.exists(cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int last);
    while (cyc <= last) begin
      bus.start = (start_at.exists(cyc) != 0);
      bus.step  = (step_at.exists(cyc) != 0);
      bus.abort = (abort_at.exists(cyc) != 0);
      tick();
    end
    bus.start = 1'b0;
    bus.step  = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic load(input logic [7:0] w);
    bus.prog_wr    = 1'b1;
    bus.prog_wdata = w;
    tick();
    bus.prog_wr    = 1'b0;
    if (mdl_prog.size() < 16) mdl_prog.push_back(w);
    else                      mdl_ovf = 1'b1;
  endtask

  task automatic clear();
    bus.prog_clr = 1'b1;
    tick();
    bus.prog_clr = 1'b0;
    mdl_prog.delete();
    mdl_ovf = 1'b0;
  endtask

  task automatic check_store(input string tag);
    check({tag, "_prog_len"}, 32'(bus.prog_len), mdl_prog.size());
    check({tag, "_load_ovf"}, 32'(bus.load_ovf), 32'(mdl_ovf));
  endtask

  // Free-run timeline: issue at start+2; a non-SEND ends its slot after GAP
  // cycles, a SEND when send_done arrives (or after TMO cycles with no answer);
  // the next issue comes 2 cycles after a slot ends, done 1 cycle after the last.
  task automatic plan(input int s, input int lat, input int ab, output int fin);
    int t, e;
    bit tmo;
    t = s + 2; fin = s + 1; tmo = 1'b0;
    for (int i = 0; i < mdl_prog.size(); i++) begin
      if (ab < 0 || t <= ab) begin
        exp_issue[t] = 1'b1;
        exp_word[t]  = mdl_prog[i];
      end
      if (mdl_prog[i][7:6] == 2'b11) begin
        if (lat == 0) begin
          fin = t + TMO;
          tmo = 1'b1;
          break;
        end
        e = t + lat;
      end else begin
        e = t + GAP;
      end
      fin = e + 1;
      t   = e + 2;
    end
    if (ab >= 0 && ab < fin) fin = ab;
    else if (!tmo)           exp_done[fin] = 1'b1;
    for (int c = s + 1; c <= fin; c++) exp_busy[c] = 1'b1;
  endtask

  int s, fin, ab, p1, p2, p3, i1, i2, i3;

  initial begin
    bus.prog_clr   = 1'b0;
    bus.prog_wr    = 1'b0;
    bus.prog_wdata = 8'h00;
    bus.start      = 1'b0;
    bus.step_mode  = 1'b0;
    bus.step       = 1'b0;
    bus.abort      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_inst_vld", 32'(bus.inst_vld), 0);
    check("rst_inst_wd",  32'(bus.inst_wd),  0);
    check("rst_busy",     32'(bus.busy),     0);
    check("rst_done",     32'(bus.done),     0);
    check("rst_err_tmo",  32'(bus.err_tmo),  0);
    check("rst_load_ovf", 32'(bus.load_ovf), 0);
    check("rst_pc",       32'(bus.pc),       0);
    check("rst_prog_len", 32'(bus.prog_len), 0);
    rst_n = 1'b1;
    tick();
    chk_on = 1'b1;

    // Mixed program with a SEND answered 50 cycles later.
    load(8'h04); load(8'h13); load(8'h86); load(8'hC0);
    check_store("t1");
    send_lat = 50;
    vld_q.delete(); done_q.delete();
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 50, -1, fin);
    run_until(fin + 3);
    check("t1_issue_count", vld_q.size(), 4);
    check("t1_done_count", done_q.size(), 1);
    if (vld_q.size() == 4 && done_q.size() == 1) begin
      check("t1_start_to_issue", vld_q[0] - s, 2);
      check("t1_spacing_12", vld_q[1] - vld_q[0], 6);
      check("t1_spacing_23", vld_q[2] - vld_q[1], 6);
      check("t1_send_to_done", done_q[0] - vld_q[3], 51);
    end
    check("t1_pc_after_done", 32'(bus.pc), 3);
    check("t1_err_tmo", 32'(bus.err_tmo), 0);

    // Empty program.
    clear();
    check_store("t2");
    done_q.delete();
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 0, -1, fin);
    run_until(fin + 2);
    check("t2_done_count", done_q.size(), 1);
    if (done_q.size() == 1) check("t2_done_lat", done_q[0] - s, 1);

    // Overflow: 17 writes into 16 entries, then replay and clear.
    for (int i = 0; i < 17; i++) load(8'(8'h20 + i));
    check_store("t3");
    check("t3_len_full", 32'(bus.prog_len), 16);
    check("t3_ovf_set", 32'(bus.load_ovf), 1);
    vld_q.delete();
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 0, -1, fin);
    run_until(fin + 2);
    check("t3_issue_count", vld_q.size(), 16);
    check("t3_pc_last", 32'(bus.pc), 15);
    clear();
    check_store("t3c");
    check("t3_len_clr", 32'(bus.prog_len), 0);
    check("t3_ovf_clr", 32'(bus.load_ovf), 0);

    // Step mode: each step in WAIT_STEP issues on the following cycle; steps
    // while idle or during the gap are ignored.
    load(8'h01); load(8'h15); load(8'h2A);
    bus.step_mode = 1'b1;
    vld_q.delete(); done_q.delete();
    step_at[cyc] = 1'b1;
    s = cyc + 2; start_at[s] = 1'b1;
    p1 = s + 6;  i1 = p1 + 1;
    p2 = i1 + 9; i2 = p2 + 1;
    p3 = i2 + 8; i3 = p3 + 1;
    fin = i3 + GAP + 1;
    step_at[p1] = 1'b1; step_at[i1 + 2] = 1'b1; step_at[p2] = 1'b1; step_at[p3] = 1'b1;
    exp_issue[i1] = 1'b1; exp_word[i1] = mdl_prog[0];
    exp_issue[i2] = 1'b1; exp_word[i2] = mdl_prog[1];
    exp_issue[i3] = 1'b1; exp_word[i3] = mdl_prog[2];
    exp_done[fin] = 1'b1;
    for (int c = s + 1; c <= fin; c++) exp_busy[c] = 1'b1;
    run_until(fin + 2);
    bus.step_mode = 1'b0;
    check("t4_issue_count", vld_q.size(), 3);
    check("t4_done_count", done_q.size(), 1);
    if (vld_q.size() == 3) check("t4_step_to_issue", vld_q[0] - p1, 1);

    // SEND never answered: timeout, no done; the next start clears err_tmo.
    clear();
    load(8'h04); load(8'hC5);
    send_lat = 0;
    vld_q.delete(); done_q.delete();
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 0, -1, fin);
    run_until(fin - 1);
    check("t5_err_before", 32'(bus.err_tmo), 0);
    run_until(fin);
    check("t5_err_set", 32'(bus.err_tmo), 1);
    check("t5_done_count", done_q.size(), 0);
    if (vld_q.size() == 2) check("t5_send_to_err", cyc - vld_q[1], 101);
    else                   check("t5_issue_count", vld_q.size(), 2);
    clear();
    load(8'hC0);
    send_lat = 10;
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 10, -1, fin);
    run_until(s);
    check("t5_err_cleared", 32'(bus.err_tmo), 0);
    run_until(fin + 2);

    // Abort during the gap after instruction 2.
    clear();
    load(8'h04); load(8'h13); load(8'h86); load(8'hC0);
    send_lat = 50;
    vld_q.delete(); done_q.delete();
    s = cyc + 1; start_at[s] = 1'b1;
    ab = s + 10; abort_at[ab] = 1'b1;
    plan(s, 50, ab, fin);
    run_until(ab + 8);
    check("t6_issue_count", vld_q.size(), 2);
    check("t6_done_count", done_q.size(), 0);
    check("t6_pc", 32'(bus.pc), 1);

    // Reset asserted mid-WAIT_SEND.
    clear();
    load(8'hC0);
    send_lat = 0;
    s = cyc + 1; start_at[s] = 1'b1;
    plan(s, 0, -1, fin);
    run_until(s + 6);
    chk_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_inst_vld", 32'(bus.inst_vld), 0);
    check("t7_inst_wd",  32'(bus.inst_wd),  0);
    check("t7_busy",     32'(bus.busy),     0);
    check("t7_done",     32'(bus.done),     0);
    check("t7_err_tmo",  32'(bus.err_tmo),  0);
    check("t7_load_ovf", 32'(bus.load_ovf), 0);
    check("t7_pc",       32'(bus.pc),       0);
    check("t7_prog_len", 32'(bus.prog_len), 0);
    tick();
    rst_n = 1'b1;
    exp_issue.delete(); exp_word.delete(); exp_done.delete(); exp_busy.delete();
    mdl_prog.delete(); mdl_ovf = 1'b0;
    chk_on = 1'b1;
    repeat (5) tick();
    check_store("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
